// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// default payload widths and the state-to-occupancy mapping.
package pipe_pkg;

  // Default payload widths: PC, ALU result, store data, rd, zero flag
  // on the datapath side; RegWrite, MemtoReg, Branch, MemWrite, MemRead
  // on the control side.
  localparam int DEF_DATA_W = 102;
  localparam int DEF_CTRL_W = 5;

  // Stage state. The encoding equals the number of held entries so
  // occupancy falls straight out of the state register.
  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_HEAD      = 2'd1;
  localparam logic [1:0] ST_HEAD_SKID = 2'd2;

  // Number of entries held in a given state.
  function automatic logic [1:0] occupancy_of(input logic [1:0] st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      ST_HEAD:      occ = 2'd1;
      ST_HEAD_SKID: occ = 2'd2;
      default:      occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_entry.sv
// One pipeline slot: valid bit, datapath payload and control payload.
// 'clear' invalidates the slot and zeroes its control bits while keeping
// the datapath bits, so a dead slot can never issue side effects
// downstream. 'clear' wins over 'load'.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Slot storage with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      ctrl  <= load_ctrl;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register. With SKID_EN=1 a second (skid)
// slot absorbs the one instruction that may arrive while downstream
// stalls, which lets in_ready come straight from a flop. With SKID_EN=0
// the stage is a single slot whose in_ready is combinational.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  stall_reg;

  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [CTRL_W-1:0] head_ctrl;
  logic              head_load;
  logic              head_clear;
  logic [DATA_W-1:0] head_load_data;
  logic [CTRL_W-1:0] head_load_ctrl;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              skid_load;
  logic              skid_clear;

  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = head_valid && out_ready;

  // Next-state logic; flush overrides any same-cycle transfer.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_xfer) state_next = ST_HEAD;
        end
        ST_HEAD: begin
          if (in_xfer && !out_xfer)
            state_next = (SKID_EN != 0) ? ST_HEAD_SKID : ST_HEAD;
          else if (!in_xfer && out_xfer)
            state_next = ST_EMPTY;
        end
        ST_HEAD_SKID: begin
          if (out_xfer) state_next = ST_HEAD;
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_EMPTY;
    else      state_reg <= state_next;
  end

  // Head refills from upstream when it is empty or draining in the same
  // cycle, or from the skid slot when that slot is occupied.
  assign head_load = !flush &&
                     ((state_reg == ST_EMPTY && in_xfer) ||
                      (state_reg == ST_HEAD && in_xfer && out_xfer) ||
                      (skid_valid && out_xfer));
  assign head_load_data = skid_valid ? skid_data : in_data;
  assign head_load_ctrl = skid_valid ? skid_ctrl : in_ctrl;
  assign head_clear     = flush || (out_xfer && !head_load);

  // Skid fills only when a new instruction arrives against a stalled head.
  assign skid_load  = !flush && (state_reg == ST_HEAD) && in_xfer && !out_xfer;
  assign skid_clear = flush || (skid_valid && out_xfer);

  pipe_stage_entry #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_head (
    .clk       (clk),
    .rst       (rst),
    .load      (head_load),
    .clear     (head_clear),
    .load_data (head_load_data),
    .load_ctrl (head_load_ctrl),
    .valid     (head_valid),
    .data      (head_data),
    .ctrl      (head_ctrl)
  );

  generate
    if (SKID_EN != 0) begin : g_skid
      logic in_ready_reg;

      pipe_stage_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
      ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_data),
        .load_ctrl (in_ctrl),
        .valid     (skid_valid),
        .data      (skid_data),
        .ctrl      (skid_ctrl)
      );

      // Registered ready: open unless the next state has both slots full.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) in_ready_reg <= 1'b1;
        else      in_ready_reg <= (state_next != ST_HEAD_SKID);
      end

      assign in_ready = in_ready_reg;
    end else begin : g_single
      assign skid_valid = 1'b0;
      assign skid_data  = '0;
      assign skid_ctrl  = '0;
      assign in_ready   = !head_valid || out_ready;
    end
  endgenerate

  // Saturating count of cycles where the head is blocked downstream;
  // deliberately ignores flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_reg <= '0;
    else if (head_valid && !out_ready && (stall_reg != CNT_MAX))
      stall_reg <= stall_reg + 1'b1;
  end

  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_ctrl  = head_ctrl;
  assign occupancy = occupancy_of(state_reg);
  assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: one skid instance (SKID_EN=1,
// CNT_W=4) and one single-entry instance (SKID_EN=0, CNT_W=16).
// Inputs change on the falling edge, outputs are checked 1 time unit
// after the rising edge.
module tb_pipe_stage_reg;

  localparam int DW = 102;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Skid instance signals
  logic          s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
  logic [DW-1:0] s_in_data, s_out_data;
  logic [CW-1:0] s_in_ctrl, s_out_ctrl;
  logic [1:0]    s_occ;
  logic [3:0]    s_stall;

  // Single-entry instance signals
  logic          n_in_valid, n_in_ready, n_flush, n_out_valid, n_out_ready;
  logic [DW-1:0] n_in_data, n_out_data;
  logic [CW-1:0] n_in_ctrl, n_out_ctrl;
  logic [1:0]    n_occ;
  logic [15:0]   n_stall;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(4)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .in_ctrl   (s_in_ctrl),
    .flush     (s_flush),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_ctrl  (s_out_ctrl),
    .occupancy (s_occ),
    .stall_cnt (s_stall)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(16)) u_single (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_data   (n_in_data),
    .in_ctrl   (n_in_ctrl),
    .flush     (n_flush),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_data  (n_out_data),
    .out_ctrl  (n_out_ctrl),
    .occupancy (n_occ),
    .stall_cnt (n_stall)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
      $display("check %s obs=%0h", tag, obs);
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    s_in_valid = 1'b0; s_in_data = '0; s_in_ctrl = '0; s_flush = 1'b0; s_out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_in_ctrl = '0; n_flush = 1'b0; n_out_ready = 1'b0;

    // ---- Reset state ----
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", s_out_valid, 1'b0);
    chk("rst_occ",       s_occ, 2'd0);
    chk("rst_in_ready",  s_in_ready, 1'b1);
    chk("rst_out_data",  s_out_data, '0);
    chk("rst_out_ctrl",  s_out_ctrl, '0);
    chk("rst_stall",     s_stall, 4'd0);
    @(negedge clk) rst = 1'b1;

    // ---- Back-to-back streaming A,B,C ----
    @(negedge clk);
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 102'hA; s_in_ctrl = 5'h11;
    tick;
    chk("str_A_valid", s_out_valid, 1'b1);
    chk("str_A_data",  s_out_data, 102'hA);
    chk("str_A_ctrl",  s_out_ctrl, 5'h11);
    chk("str_A_occ",   s_occ, 2'd1);
    @(negedge clk); s_in_data = 102'hB; s_in_ctrl = 5'h12;
    tick;
    chk("str_B_data",  s_out_data, 102'hB);
    chk("str_B_occ",   s_occ, 2'd1);
    chk("str_B_ready", s_in_ready, 1'b1);
    @(negedge clk); s_in_data = 102'hC; s_in_ctrl = 5'h13;
    tick;
    chk("str_C_data",  s_out_data, 102'hC);
    chk("str_C_occ",   s_occ, 2'd1);
    @(negedge clk); s_in_valid = 1'b0;
    tick;
    chk("str_end_valid", s_out_valid, 1'b0);
    chk("str_end_ctrl",  s_out_ctrl, 5'h00);
    chk("str_end_occ",   s_occ, 2'd0);
    chk("str_end_data",  s_out_data, 102'hC);

    // ---- Backpressure A2,B2 ----
    @(negedge clk);
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 102'hA2; s_in_ctrl = 5'h15;
    tick;
    chk("bp_1_occ",   s_occ, 2'd1);
    chk("bp_1_ready", s_in_ready, 1'b1);
    @(negedge clk); s_in_data = 102'hB2; s_in_ctrl = 5'h16;
    tick;
    chk("bp_2_occ",   s_occ, 2'd2);
    chk("bp_2_ready", s_in_ready, 1'b0);
    chk("bp_2_data",  s_out_data, 102'hA2);
    chk("bp_2_stall", s_stall, 4'd1);
    @(negedge clk); s_in_data = 102'hFF; s_in_ctrl = 5'h1F;
    tick;
    chk("bp_ign_occ",   s_occ, 2'd2);
    chk("bp_ign_data",  s_out_data, 102'hA2);
    chk("bp_ign_ctrl",  s_out_ctrl, 5'h15);
    chk("bp_ign_stall", s_stall, 4'd2);
    @(negedge clk); s_in_valid = 1'b0; s_out_ready = 1'b1;
    tick;
    chk("bp_B_data",  s_out_data, 102'hB2);
    chk("bp_B_ctrl",  s_out_ctrl, 5'h16);
    chk("bp_B_occ",   s_occ, 2'd1);
    chk("bp_B_ready", s_in_ready, 1'b1);
    tick;
    chk("bp_end_valid", s_out_valid, 1'b0);
    chk("bp_end_occ",   s_occ, 2'd0);
    chk("bp_end_stall", s_stall, 4'd2);

    // ---- Flush with both entries full and in_valid=1 ----
    @(negedge clk);
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 102'hD1; s_in_ctrl = 5'h07;
    tick;
    @(negedge clk); s_in_data = 102'hD2; s_in_ctrl = 5'h08;
    tick;
    chk("fl_full_occ",   s_occ, 2'd2);
    chk("fl_full_stall", s_stall, 4'd3);
    @(negedge clk); s_in_data = 102'hD3; s_in_ctrl = 5'h09; s_flush = 1'b1;
    tick;
    chk("fl_valid", s_out_valid, 1'b0);
    chk("fl_ctrl",  s_out_ctrl, 5'b00000);
    chk("fl_occ",   s_occ, 2'd0);
    chk("fl_ready", s_in_ready, 1'b1);
    chk("fl_data",  s_out_data, 102'hD1);
    chk("fl_stall", s_stall, 4'd4);
    @(negedge clk); s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    tick;
    chk("fl_after_valid", s_out_valid, 1'b0);
    chk("fl_after_occ",   s_occ, 2'd0);
    chk("fl_after_stall", s_stall, 4'd4);

    // ---- SKID_EN=0 with out_ready 1,0,1 ----
    @(negedge clk);
    n_out_ready = 1'b1; n_in_valid = 1'b1; n_in_data = 102'h101; n_in_ctrl = 5'h03;
    #1 chk("se_empty_ready", n_in_ready, 1'b1);
    tick;
    chk("se_H1_valid", n_out_valid, 1'b1);
    chk("se_H1_data",  n_out_data, 102'h101);
    @(negedge clk); n_in_data = 102'h102; n_in_ctrl = 5'h04;
    #1 chk("se_rdy1", n_in_ready, 1'b1);
    tick;
    chk("se_H2_data", n_out_data, 102'h102);
    chk("se_H2_occ",  n_occ, 2'd1);
    @(negedge clk); n_out_ready = 1'b0; n_in_data = 102'h103; n_in_ctrl = 5'h05;
    #1 chk("se_rdy0", n_in_ready, 1'b0);
    tick;
    chk("se_hold_data",  n_out_data, 102'h102);
    chk("se_hold_ctrl",  n_out_ctrl, 5'h04);
    chk("se_hold_occ",   n_occ, 2'd1);
    chk("se_hold_stall", n_stall, 16'd1);
    @(negedge clk); n_out_ready = 1'b1;
    #1 chk("se_rdy1b", n_in_ready, 1'b1);
    tick;
    chk("se_H3_data", n_out_data, 102'h103);
    chk("se_H3_ctrl", n_out_ctrl, 5'h05);
    @(negedge clk); n_in_valid = 1'b0;
    tick;
    chk("se_end_valid", n_out_valid, 1'b0);
    chk("se_end_occ",   n_occ, 2'd0);

    // ---- Stall counter saturation (CNT_W=4) ----
    @(negedge clk);
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 102'hE; s_in_ctrl = 5'h1A;
    tick;
    @(negedge clk); s_in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick;
    chk("sat_stall", s_stall, 4'd15);
    chk("sat_valid", s_out_valid, 1'b1);
    chk("sat_data",  s_out_data, 102'hE);
    chk("sat_occ",   s_occ, 2'd1);
    @(negedge clk); s_flush = 1'b1;
    tick;
    chk("sat_fl_valid", s_out_valid, 1'b0);
    chk("sat_fl_stall", s_stall, 4'd15);
    @(negedge clk); s_flush = 1'b0;
    tick;
    chk("sat_fl_stall2", s_stall, 4'd15);

    // ---- Asynchronous reset at occupancy 2 ----
    @(negedge clk);
    s_in_valid = 1'b1; s_in_data = 102'hF1; s_in_ctrl = 5'h0C;
    tick;
    @(negedge clk); s_in_data = 102'hF2; s_in_ctrl = 5'h0D;
    tick;
    chk("ar_pre_occ",   s_occ, 2'd2);
    chk("ar_pre_ready", s_in_ready, 1'b0);
    @(negedge clk); s_in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("ar_valid", s_out_valid, 1'b0);
    chk("ar_occ",   s_occ, 2'd0);
    chk("ar_ready", s_in_ready, 1'b1);
    chk("ar_data",  s_out_data, '0);
    chk("ar_ctrl",  s_out_ctrl, '0);
    chk("ar_stall", s_stall, 4'd0);
    @(negedge clk);
    rst = 1'b1; s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 102'h6; s_in_ctrl = 5'h1E;
    tick;
    chk("ar_post_valid", s_out_valid, 1'b1);
    chk("ar_post_data",  s_out_data, 102'h6);
    chk("ar_post_ctrl",  s_out_ctrl, 5'h1E);
    chk("ar_post_occ",   s_occ, 2'd1);
    @(negedge clk); s_in_valid = 1'b0;
    tick;
    chk("ar_drain_valid", s_out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
